// File: rtl/next_pc_unit_pkg.sv
// Shared types and constants for the next-PC unit: FSM states, redirect
// sources and the two sequential increment sizes.
package next_pc_unit_pkg;

    // RUN: no redirect waiting; HOLD: a redirect was captured during a stall.
    typedef enum logic {
        RUN,
        HOLD
    } state_e;

    // Where the next PC comes from, in increasing priority order.
    typedef enum logic [1:0] {
        SEQ,
        BR,
        JMP,
        TRAP
    } src_e;

    // Sequential step sizes for 16-bit and 32-bit instructions.
    localparam int unsigned INC_HALF = 2;
    localparam int unsigned INC_WORD = 4;

endpackage : next_pc_unit_pkg

// File: rtl/next_pc_unit_target_sel.sv
// Combinational redirect selection. Picks the highest-priority redirect,
// cleans its low bits and rejects misaligned jump/branch targets.
module pc_target_sel
    import next_pc_unit_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 32
) (
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic            redir_valid_o,
    output logic            redir_is_trap_o,
    output logic [XLEN-1:0] redir_target_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    // Trap vectors drop log2(IALIGN/8) low bits, so they can never be misaligned.
    localparam logic [XLEN-1:0] TRAP_MASK = (IALIGN == 32) ? XLEN'(3) : XLEN'(1);

    src_e            src;
    logic [XLEN-1:0] jmp_clean;
    logic [XLEN-1:0] trap_clean;
    logic            jmp_misaligned;
    logic            br_misaligned;

    assign jmp_clean  = jump_target_i & ~XLEN'(1);
    assign trap_clean = trap_vec_i & ~TRAP_MASK;

    // Bit 0 of a jump is always cleared, so jumps only fault on bit 1 with
    // 32-bit alignment; branches fault on bit 1 (IALIGN=32) or bit 0 (IALIGN=16).
    assign jmp_misaligned = (IALIGN == 32) ? jmp_clean[1] : 1'b0;
    assign br_misaligned  = (IALIGN == 32) ? br_target_i[1] : br_target_i[0];

    // Priority encode the live redirect requests.
    always_comb begin
        if (trap_i)          src = TRAP;
        else if (jump_i)     src = JMP;
        else if (br_taken_i) src = BR;
        else                 src = SEQ;
    end

    // Resolve the chosen source into a loadable target or a misalign event.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and infers a latch.
    always_comb begin
        redir_valid_o   = 1'b0;
        redir_is_trap_o = 1'b0;
        redir_target_o  = trap_clean;
        misalign_o      = 1'b0;
        misalign_addr_o = jmp_clean;
        unique case (src)
            TRAP: begin
                redir_valid_o   = 1'b1;
                redir_is_trap_o = 1'b1;
                redir_target_o  = trap_clean;
            end
            JMP: begin
                redir_target_o  = jmp_clean;
                misalign_addr_o = jmp_clean;
                if (jmp_misaligned) misalign_o    = 1'b1;
                else                redir_valid_o = 1'b1;
            end
            BR: begin
                redir_target_o  = br_target_i;
                misalign_addr_o = br_target_i;
                if (br_misaligned) misalign_o    = 1'b1;
                else               redir_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule : pc_target_sel

// File: rtl/next_pc_unit.sv
// Program counter with sequential increment, prioritised redirects, a
// one-entry pending redirect buffer for stalls, and misalign reporting.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h20,
    parameter int unsigned IALIGN   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            compressed_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_seq_o,
    output logic            redirect_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            pend_trap_q, pend_trap_d;
    logic            redirect_q, redirect_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] maddr_q, maddr_d;

    logic            sel_valid;
    logic            sel_is_trap;
    logic [XLEN-1:0] sel_target;
    logic            sel_misalign;
    logic [XLEN-1:0] sel_maddr;
    logic [XLEN-1:0] inc;

    pc_target_sel #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target_sel (
        .br_taken_i      (br_taken_i),
        .br_target_i     (br_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .trap_i          (trap_i),
        .trap_vec_i      (trap_vec_i),
        .redir_valid_o   (sel_valid),
        .redir_is_trap_o (sel_is_trap),
        .redir_target_o  (sel_target),
        .misalign_o      (sel_misalign),
        .misalign_addr_o (sel_maddr)
    );

    // Compressed instructions only shorten the step when 16-bit alignment is enabled.
    assign inc      = ((IALIGN == 16) && compressed_i) ? XLEN'(INC_HALF) : XLEN'(INC_WORD);
    assign pc_seq_o = pc_q + inc;

    // Next-state logic for the PC, pending buffer, FSM and registered pulses.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_trap_d   = pend_trap_q;
        redirect_d    = 1'b0;
        misalign_d    = sel_misalign;
        maddr_d       = sel_misalign ? sel_maddr : maddr_q;

        if (stall_i) begin
            // Capture valid redirects; a pending trap yields only to a newer trap.
            if (sel_valid) begin
                if ((state_q == RUN) || !pend_trap_q || sel_is_trap) begin
                    pend_target_d = sel_target;
                    pend_trap_d   = sel_is_trap;
                end
                state_d = HOLD;
            end
        end else begin
            state_d     = RUN;
            pend_trap_d = 1'b0;
            if (sel_valid && sel_is_trap) begin
                pc_d       = sel_target;
                redirect_d = 1'b1;
            end else if (state_q == HOLD) begin
                pc_d       = pend_target_q;
                redirect_d = 1'b1;
            end else if (sel_valid) begin
                pc_d       = sel_target;
                redirect_d = 1'b1;
            end else begin
                pc_d = pc_seq_o;
            end
        end
    end

    // State registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= XLEN'(RESET_PC);
            pend_trap_q <= 1'b0;
            redirect_q  <= 1'b0;
            misalign_q  <= 1'b0;
            maddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_trap_q <= pend_trap_d;
            redirect_q  <= redirect_d;
            misalign_q  <= misalign_d;
            maddr_q     <= maddr_d;
        end
    end

    // Pending target payload; only meaningful while in HOLD.
    // NOTE: datapath payload needs no reset because state_q qualifies it.
    always_ff @(posedge clk) begin
        pend_target_q <= pend_target_d;
    end

    assign pc_o            = pc_q;
    assign redirect_o      = redirect_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = maddr_q;

endmodule : next_pc_unit
